uart_rx_frame_ctrl: RTL and testbench
=====================================

# uart_rx_frame_ctrl

Frame controller that sits directly behind the UART receiver and sequences its byte stream into command frames for the debug/loader unit. It consumes the receiver's one-cycle done strobe and data byte, assembles one command byte plus a fixed number of little-endian payload bytes, and presents the frame on a valid/ready interface. It also discards partial frames on inter-byte timeout, flags bytes lost while a frame is held, and optionally checks a trailing XOR checksum.

## Interface
Parameters:
- DATA_BITS, 8, receiver byte width
- WORD_BYTES, 4, payload bytes per frame (≥1)
- TIMEOUT_CYCLES, 100000, clk cycles allowed between bytes of one frame (≥2)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- rx_done_tick  in  1  one-cycle strobe: rx_data holds a new byte
- rx_data  in  DATA_BITS  received byte
- frame_valid  out  1  frame available
- frame_ready  in  1  consumer accepts frame
- frame_cmd  out  DATA_BITS  command byte
- frame_data  out  WORD_BYTES*DATA_BITS  payload, byte 1 in bits [DATA_BITS-1:0]
- frame_err  out  1  one-cycle pulse: frame dropped (timeout or checksum)
- overrun  out  1  one-cycle pulse: byte lost while frame held

## Operation
- States: IDLE, DATA, CHK (only when checksum enabled), HOLD.
- IDLE: on rx_done_tick latch rx_data into frame_cmd, clear byte counter, clear timeout counter, checksum accumulator := rx_data, go DATA.
- DATA: each rx_done_tick writes rx_data into payload slot n (little-endian), XORs into accumulator, n := n+1; when n == WORD_BYTES-1 is written, go CHK (macro on) or HOLD (macro off).
- CHK: next rx_done_tick compares rx_data to accumulator; equal → HOLD; unequal → frame_err pulse, go IDLE.
- HOLD: frame_valid high; frame_cmd/frame_data stable. frame_valid & frame_ready → IDLE. rx_done_tick in HOLD without handshake → byte dropped, overrun pulse, stay HOLD.
- Simultaneous handshake and rx_done_tick in HOLD: byte taken as new command byte, next state DATA, no overrun.
- Timeout counter: clears on every accepted byte; increments each cycle in DATA/CHK; reaching TIMEOUT_CYCLES-1 without a byte → frame_err pulse, go IDLE, partial payload discarded. rx_done_tick in the terminal-count cycle wins (byte accepted, no error). Counter idle in IDLE/HOLD.
- Byte counter width clog2(WORD_BYTES) min 1; timeout counter width clog2(TIMEOUT_CYCLES); no wrap possible.

## Timing
- Reset values: frame_valid 0, frame_err 0, overrun 0, frame_cmd 0, frame_data 0, state IDLE, counters 0.
- frame_valid rises the cycle after the rx_done_tick of the final byte (payload last or checksum).
- frame_valid falls the cycle after the handshake cycle.
- frame_err/overrun: registered, high exactly one cycle, the cycle after the causing event.
- Reset assertion mid-frame: immediate return to IDLE, all outputs to reset values, partial frame lost.

## Configuration
- UART_FRAME_CHECKSUM_EN defined: CHK state present, frame is 1+WORD_BYTES+1 bytes, checksum = XOR of command and payload bytes, mismatch → frame_err.
- Undefined: CHK state and accumulator absent, frame is 1+WORD_BYTES bytes, frame_err only from timeout.

## Structure
- Shared package/header: state encodings (FRAME_STATE_IDLE/DATA/CHK/HOLD), state register width, default parameter values alongside the existing UART constants.
- One sub-module natural: uart_frame_timer (loadable timeout counter with clear input and terminal-count output).

## Test plan
- WORD_BYTES=4, bytes 0x10,0x44,0x33,0x22,0x11, frame_ready=1 → frame_valid one cycle, frame_cmd=0x10, frame_data=0x11223344.
- Frame complete, frame_ready=0, extra byte 0x55 → overrun pulse once, frame_data unchanged; then ready → IDLE.
- Bytes 0x10,0x44 then silence TIMEOUT_CYCLES cycles → frame_err pulse, no frame_valid; next 5 bytes form a correct frame.
- Macro on: 0x01,0x02,0x03,0x04,0x05,checksum 0x01 → frame_valid; same with checksum 0x00 → frame_err, no frame_valid.
- Handshake and new rx_done_tick (0x20) same cycle → state DATA, frame_cmd later 0x20, no overrun.
- reset low after 2 of 5 bytes → all outputs 0, next full frame received correctly.

Source files
------------

// File: rtl/uart_rx_frame_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_frame_ctrl_pkg
// Description : Shared constants for the UART receive path. This package holds
//               the default receiver/frame parameters and the frame-controller
//               state encodings. It also holds a helper that sizes counters.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_frame_ctrl_pkg;

    // Default UART receive-path parameters
    localparam int UART_DATA_BITS      = 8;
    localparam int UART_WORD_BYTES     = 4;
    localparam int UART_TIMEOUT_CYCLES = 100000;

    // Frame controller state register width and encodings
    localparam int                       FRAME_STATE_W    = 2;
    localparam logic [FRAME_STATE_W-1:0] FRAME_STATE_IDLE = 2'd0;
    localparam logic [FRAME_STATE_W-1:0] FRAME_STATE_DATA = 2'd1;
    localparam logic [FRAME_STATE_W-1:0] FRAME_STATE_CHK  = 2'd2;
    localparam logic [FRAME_STATE_W-1:0] FRAME_STATE_HOLD = 2'd3;

    // Counter width able to index 0..n-1, never narrower than one bit
    function automatic int frame_cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_timer
// Description : Inter-byte timeout counter for the frame controller. The count
//               returns to zero when i_clear is high. It advances when
//               i_enable is high and stops at the terminal count
//               TIMEOUT_CYCLES-1. o_terminal is high while the count sits at
//               that terminal value.
// Ports       : clk        - system clock
//               reset      - asynchronous active-low reset
//               i_clear    - load zero (takes priority over i_enable)
//               i_enable   - count this cycle
//               o_terminal - count equals TIMEOUT_CYCLES-1
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_timer
    import uart_rx_frame_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = UART_TIMEOUT_CYCLES
)(
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int               CNT_W      = frame_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // The count stops at terminal so it can never wrap back to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !o_terminal) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_terminal = (r_cnt == c_cnt_last);

endmodule
`default_nettype wire

// File: rtl/uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_frame_ctrl
// Description : Assembles the UART receiver byte stream into command frames.
//               A frame is one command byte followed by WORD_BYTES
//               little-endian payload bytes. The frame is offered on a
//               valid/ready interface. The controller drops a partial frame
//               on inter-byte timeout. It flags bytes that arrive while a
//               frame is held.
//               Optional feature macro: UART_FRAME_CHECKSUM_EN. When it is
//               defined, one trailing byte is expected. That byte must equal
//               the XOR of the command and payload bytes.
// Ports       : clk          - system clock, rising edge
//               reset        - asynchronous active-low reset
//               rx_done_tick - one-cycle strobe, rx_data holds a new byte
//               rx_data      - received byte
//               frame_valid  - frame available
//               frame_ready  - consumer accepts frame
//               frame_cmd    - command byte
//               frame_data   - payload, byte 1 in the low bits
//               frame_err    - one-cycle pulse, frame dropped
//               overrun      - one-cycle pulse, byte lost while frame held
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_frame_ctrl
    import uart_rx_frame_ctrl_pkg::*;
#(
    parameter int DATA_BITS      = UART_DATA_BITS,
    parameter int WORD_BYTES     = UART_WORD_BYTES,
    parameter int TIMEOUT_CYCLES = UART_TIMEOUT_CYCLES
)(
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            rx_done_tick,
    input  logic [DATA_BITS-1:0]            rx_data,
    output logic                            frame_valid,
    input  logic                            frame_ready,
    output logic [DATA_BITS-1:0]            frame_cmd,
    output logic [WORD_BYTES*DATA_BITS-1:0] frame_data,
    output logic                            frame_err,
    output logic                            overrun
);

    localparam int                BCNT_W      = frame_cnt_width(WORD_BYTES);
    localparam logic [BCNT_W-1:0] c_bcnt_last = BCNT_W'(WORD_BYTES - 1);

`ifdef UART_FRAME_CHECKSUM_EN
    localparam logic [FRAME_STATE_W-1:0] c_after_data = FRAME_STATE_CHK;
`else
    localparam logic [FRAME_STATE_W-1:0] c_after_data = FRAME_STATE_HOLD;
`endif

    logic [FRAME_STATE_W-1:0]        r_state;
    logic [FRAME_STATE_W-1:0]        w_state_nxt;
    logic [BCNT_W-1:0]               r_bcnt;
    logic [DATA_BITS-1:0]            r_cmd;
    logic [WORD_BYTES*DATA_BITS-1:0] r_data;
    logic                            r_err;
    logic                            r_ovr;

    logic w_take_cmd;   // rx_data starts a new frame
    logic w_take_data;  // rx_data goes into payload slot r_bcnt
    logic w_err;
    logic w_ovr;
    logic w_tmo_clear;
    logic w_tmo_en;
    logic w_tmo_tc;

`ifdef UART_FRAME_CHECKSUM_EN
    logic [DATA_BITS-1:0] r_acc;
`endif

    uart_frame_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_tmo_clear),
        .i_enable   (w_tmo_en),
        .o_terminal (w_tmo_tc)
    );

    // ------------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_take_cmd  = 1'b0;
        w_take_data = 1'b0;
        w_err       = 1'b0;
        w_ovr       = 1'b0;
        w_tmo_clear = 1'b0;
        w_tmo_en    = 1'b0;

        case (r_state)
            FRAME_STATE_IDLE: begin
                if (rx_done_tick) begin
                    w_take_cmd  = 1'b1;
                    w_tmo_clear = 1'b1;
                    w_state_nxt = FRAME_STATE_DATA;
                end
            end

            FRAME_STATE_DATA: begin
                w_tmo_en = 1'b1;
                // A byte in the terminal-count cycle still counts as on time.
                if (rx_done_tick) begin
                    w_take_data = 1'b1;
                    w_tmo_clear = 1'b1;
                    if (r_bcnt == c_bcnt_last) begin
                        w_state_nxt = c_after_data;
                    end
                end else if (w_tmo_tc) begin
                    w_err       = 1'b1;
                    w_tmo_clear = 1'b1;
                    w_state_nxt = FRAME_STATE_IDLE;
                end
            end

`ifdef UART_FRAME_CHECKSUM_EN
            FRAME_STATE_CHK: begin
                w_tmo_en = 1'b1;
                if (rx_done_tick) begin
                    w_tmo_clear = 1'b1;
                    if (rx_data == r_acc) begin
                        w_state_nxt = FRAME_STATE_HOLD;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = FRAME_STATE_IDLE;
                    end
                end else if (w_tmo_tc) begin
                    w_err       = 1'b1;
                    w_tmo_clear = 1'b1;
                    w_state_nxt = FRAME_STATE_IDLE;
                end
            end
`endif

            FRAME_STATE_HOLD: begin
                if (frame_ready) begin
                    w_state_nxt = FRAME_STATE_IDLE;
                    // A byte that arrives on the handshake cycle starts the next frame.
                    if (rx_done_tick) begin
                        w_take_cmd  = 1'b1;
                        w_tmo_clear = 1'b1;
                        w_state_nxt = FRAME_STATE_DATA;
                    end
                end else if (rx_done_tick) begin
                    w_ovr = 1'b1;
                end
            end

            default: begin
                w_state_nxt = FRAME_STATE_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and frame registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FRAME_STATE_IDLE;
            r_bcnt  <= '0;
            r_cmd   <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err;
            r_ovr   <= w_ovr;
            if (w_take_cmd) begin
                r_cmd  <= rx_data;
                r_bcnt <= '0;
            end
            if (w_take_data) begin
                for (int i = 0; i < WORD_BYTES; i++) begin
                    if (r_bcnt == BCNT_W'(i)) begin
                        r_data[i*DATA_BITS +: DATA_BITS] <= rx_data;
                    end
                end
                // The counter stops at the last slot so it never wraps.
                if (r_bcnt != c_bcnt_last) begin
                    r_bcnt <= r_bcnt + BCNT_W'(1);
                end
            end
        end
    end

`ifdef UART_FRAME_CHECKSUM_EN
    // Running XOR of the command and payload bytes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
        end else if (w_take_cmd) begin
            r_acc <= rx_data;
        end else if (w_take_data) begin
            r_acc <= r_acc ^ rx_data;
        end
    end
`endif

    assign frame_valid = (r_state == FRAME_STATE_HOLD);
    assign frame_cmd   = r_cmd;
    assign frame_data  = r_data;
    assign frame_err   = r_err;
    assign overrun     = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_frame_ctrl
// Description : Self-checking bench for uart_rx_frame_ctrl. A frame-level
//               model holds the collected bytes in a queue. Every cycle the
//               bench compares the DUT against this model. It also runs
//               directed scenarios that check literal values, and then
//               random stimulus. The checksum macro is
//               UART_FRAME_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame_ctrl;

    localparam int WB = 4;
    localparam int TC = 16;
`ifdef UART_FRAME_CHECKSUM_EN
    localparam int CHK_BYTES = 1;
`else
    localparam int CHK_BYTES = 0;
`endif
    localparam int FLEN = 1 + WB + CHK_BYTES;

    logic          clk;
    logic          reset;
    logic          rx_done_tick;
    logic [7:0]    rx_data;
    logic          frame_valid;
    logic          frame_ready;
    logic [7:0]    frame_cmd;
    logic [8*WB-1:0] frame_data;
    logic          frame_err;
    logic          overrun;

    int n_cmp = 0;
    int n_bad = 0;

    uart_rx_frame_ctrl #(
        .DATA_BITS      (8),
        .WORD_BYTES     (WB),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .frame_cmd    (frame_cmd),
        .frame_data   (frame_data),
        .frame_err    (frame_err),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Frame-level reference model: collected bytes, idle gap, held frame
    // ------------------------------------------------------------------------
    logic [7:0]      fb[$];
    int              gap;
    bit              m_hold;
    bit              m_err;
    bit              m_ovr;
    logic [7:0]      m_cmd;
    logic [8*WB-1:0] m_data;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            fb.delete();
            gap    = 0;
            m_hold = 0;
            m_err  = 0;
            m_ovr  = 0;
            m_cmd  = '0;
            m_data = '0;
        end else begin
            m_err = 0;
            m_ovr = 0;
            if (m_hold) begin
                if (frame_ready) begin
                    m_hold = 0;
                    if (rx_done_tick) begin
                        fb.push_back(rx_data);
                        gap = 0;
                    end
                end else if (rx_done_tick) begin
                    m_ovr = 1;
                end
            end else if (fb.size() == 0) begin
                if (rx_done_tick) begin
                    fb.push_back(rx_data);
                    gap = 0;
                end
            end else if (rx_done_tick) begin
                fb.push_back(rx_data);
                gap = 0;
                if (fb.size() == FLEN) begin
                    logic [7:0] x;
                    x = '0;
                    for (int i = 0; i < 1 + WB; i++) x ^= fb[i];
                    if (CHK_BYTES == 1 && x != fb[FLEN-1]) begin
                        m_err = 1;
                    end else begin
                        m_hold = 1;
                        m_cmd  = fb[0];
                        for (int i = 0; i < WB; i++) m_data[8*i +: 8] = fb[1+i];
                    end
                    fb.delete();
                end
            end else begin
                gap++;
                if (gap == TC) begin
                    m_err = 1;
                    fb.delete();
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (reset) begin
            chk("valid", 64'(frame_valid), 64'(m_hold));
            chk("frame_err", 64'(frame_err), 64'(m_err));
            chk("overrun", 64'(overrun), 64'(m_ovr));
            if (m_hold) begin
                chk("cmd", 64'(frame_cmd), 64'(m_cmd));
                chk("data", 64'(frame_data), 64'(m_data));
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers; inputs change only just after a falling edge
    // ------------------------------------------------------------------------
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_done_tick = 1'b1;
        rx_data      = b;
        @(negedge clk);
        rx_done_tick = 1'b0;
    endtask

    task automatic send_tail(input logic [7:0] cmd, input logic [8*WB-1:0] data, input bit bad);
        logic [7:0] x;
        x = cmd;
        for (int i = 0; i < WB; i++) begin
            send(data[8*i +: 8]);
            x ^= data[8*i +: 8];
        end
        if (CHK_BYTES == 1) send(x ^ {7'd0, bad});
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [8*WB-1:0] data, input bit bad);
        send(cmd);
        send_tail(cmd, data, bad);
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation did not finish in time");
        summary();
        $fatal(1, "watchdog");
    end

    initial begin
        int n_e;
        int n_v;
        reset        = 1'b0;
        rx_done_tick = 1'b0;
        rx_data      = '0;
        frame_ready  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(frame_valid), 64'd0);
        chk("rst_err", 64'(frame_err), 64'd0);
        chk("rst_ovr", 64'(overrun), 64'd0);
        chk("rst_cmd", 64'(frame_cmd), 64'd0);
        chk("rst_data", 64'(frame_data), 64'd0);
        reset = 1'b1;

        // Basic frame held, then overrun, then handshake
        send_frame(8'h10, 32'h11223344, 0);
        chk("t1_valid", 64'(frame_valid), 64'd1);
        chk("t1_cmd", 64'(frame_cmd), 64'h10);
        chk("t1_data", 64'(frame_data), 64'h11223344);
        chk("t1_model_data", 64'(m_data), 64'h11223344);
        send(8'h55);
        chk("t2_ovr_pulse", 64'(overrun), 64'd1);
        chk("t2_data_kept", 64'(frame_data), 64'h11223344);
        @(negedge clk);
        chk("t2_ovr_once", 64'(overrun), 64'd0);
        frame_ready = 1'b1;
        @(negedge clk);
        chk("t2_released", 64'(frame_valid), 64'd0);

        // Timeout after two bytes
        send(8'h10);
        send(8'h44);
        n_e = 0;
        n_v = 0;
        for (int i = 0; i < TC + 4; i++) begin
            @(negedge clk);
            n_e += int'(frame_err);
            n_v += int'(frame_valid);
        end
        chk("t3_err_count", 64'(n_e), 64'd1);
        chk("t3_no_valid", 64'(n_v), 64'd0);
        send_frame(8'h10, 32'h11223344, 0);
        chk("t3_next_valid", 64'(frame_valid), 64'd1);
        chk("t3_next_data", 64'(frame_data), 64'h11223344);
        @(negedge clk);
        chk("t3_valid_one_cycle", 64'(frame_valid), 64'd0);

        // Handshake and new byte on the same cycle
        frame_ready = 1'b0;
        send_frame(8'hA5, 32'hDEADBEEF, 0);
        chk("t4_held", 64'(frame_valid), 64'd1);
        frame_ready  = 1'b1;
        rx_done_tick = 1'b1;
        rx_data      = 8'h20;
        @(negedge clk);
        rx_done_tick = 1'b0;
        frame_ready  = 1'b0;
        chk("t4_no_ovr", 64'(overrun), 64'd0);
        chk("t4_valid_low", 64'(frame_valid), 64'd0);
        send_tail(8'h20, 32'h04030201, 0);
        chk("t4_valid", 64'(frame_valid), 64'd1);
        chk("t4_cmd", 64'(frame_cmd), 64'h20);
        chk("t4_data", 64'(frame_data), 64'h04030201);
        frame_ready = 1'b1;
        @(negedge clk);

`ifdef UART_FRAME_CHECKSUM_EN
        // Checksum good (0x01) and bad (0x00)
        send_frame(8'h01, 32'h05040302, 0);
        chk("t5_good_valid", 64'(frame_valid), 64'd1);
        chk("t5_good_data", 64'(frame_data), 64'h05040302);
        @(negedge clk);
        send_frame(8'h01, 32'h05040302, 1);
        chk("t5_bad_err", 64'(frame_err), 64'd1);
        chk("t5_bad_novalid", 64'(frame_valid), 64'd0);
        @(negedge clk);
`endif

        // Reset in the middle of a frame
        send(8'h77);
        send(8'h66);
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(frame_valid), 64'd0);
        chk("t6_rst_cmd", 64'(frame_cmd), 64'd0);
        chk("t6_rst_data", 64'(frame_data), 64'd0);
        chk("t6_rst_err", 64'(frame_err), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        frame_ready = 1'b0;
        send_frame(8'h3C, 32'hCAFEF00D, 0);
        chk("t6_after_cmd", 64'(frame_cmd), 64'h3C);
        chk("t6_after_data", 64'(frame_data), 64'hCAFEF00D);
        frame_ready = 1'b1;
        @(negedge clk);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                frame_ready = ($urandom_range(0, 1) == 1);
                send_frame(8'($urandom), 32'($urandom), 0);
            end else if ($urandom_range(0, 120) == 0) begin
                @(negedge clk);
                rx_done_tick = 1'b0;
                frame_ready  = ($urandom_range(0, 1) == 1);
                repeat (TC + 2) @(negedge clk);
            end else begin
                @(negedge clk);
                rx_done_tick = ($urandom_range(0, 3) == 0);
                rx_data      = 8'($urandom);
                frame_ready  = ($urandom_range(0, 2) != 0);
            end
        end

        @(negedge clk);
        rx_done_tick = 1'b0;
        repeat (5) @(negedge clk);
        summary();
        $finish;
    end

endmodule
`default_nettype wire
